// File: rtl/dct_transpose_ctrl_if.sv
// Stream and RAM-port bundle for the DCT transpose-buffer controller.
// master = controller side, slave = row/column stages plus RAM.
interface dct_transpose_ctrl_if #(
   parameter int unsigned DATA_W = 16
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;
   logic [5:0]        ram_address;
   logic [DATA_W-1:0] ram_data_in;
   logic              ram_cs;
   logic              ram_read;
   logic              ram_write;
   logic [DATA_W-1:0] ram_data_out;

   modport master (
      input  in_valid, in_data, out_ready, ram_data_out,
      output in_ready, out_valid, out_data, out_last,
             ram_address, ram_data_in, ram_cs, ram_read, ram_write
   );

   modport slave (
      output in_valid, in_data, out_ready, ram_data_out,
      input  in_ready, out_valid, out_data, out_last,
             ram_address, ram_data_in, ram_cs, ram_read, ram_write
   );
endinterface

// File: rtl/dct_transpose_ctrl.sv
// Transpose-buffer controller: fills the 64-word RAM row-major, drains it
// column-major through a 2-entry skid buffer with valid/ready backpressure.
module dct_transpose_ctrl #(
   parameter int unsigned DATA_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   dct_transpose_ctrl_if.master bus
);
   typedef enum logic {FILL, DRAIN} state_e;

   state_e            state_q;
   logic [5:0]        wr_idx_q;
   logic [6:0]        rd_idx_q;
   logic [1:0]        count_q, count_d;
   logic [DATA_W-1:0] head_q, tail_q;
   logic              head_last_q, tail_last_q;
   logic [5:0]        ram_address_q;
   logic [DATA_W-1:0] ram_data_in_q;
   logic              ram_cs_q, ram_read_q, ram_write_q;

   logic              accept, issue, push, push_last, pop;
   logic [1:0]        slot;

   // Reads are throttled so skid entries plus the one read in flight never exceed two.
   always_comb begin
      accept    = (state_q == FILL) && bus.in_valid;
      pop       = (count_q != 2'd0) && bus.out_ready;
      push      = ram_read_q;
      push_last = ram_read_q && (rd_idx_q == 7'd64);
      issue     = (state_q == DRAIN) && !rd_idx_q[6] &&
                  (({1'b0, count_q} + {2'b0, ram_read_q} + 3'd1) <= (3'd2 + {2'b0, pop}));
      count_d   = count_q + {1'b0, push} - {1'b0, pop};
      slot      = count_q - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FILL;
         wr_idx_q      <= '0;
         rd_idx_q      <= '0;
         count_q       <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         head_last_q   <= 1'b0;
         tail_last_q   <= 1'b0;
         ram_address_q <= '0;
         ram_data_in_q <= '0;
         ram_cs_q      <= 1'b0;
         ram_read_q    <= 1'b0;
         ram_write_q   <= 1'b0;
      end else begin
         count_q     <= count_d;
         ram_write_q <= accept;
         ram_read_q  <= issue;
         ram_cs_q    <= accept | issue;

         // Pop shifts the tail forward; a push into the freed slot overrides it.
         if (pop) begin
            head_q      <= tail_q;
            head_last_q <= tail_last_q;
         end
         if (push) begin
            if (slot == 2'd0) begin
               head_q      <= bus.ram_data_out;
               head_last_q <= push_last;
            end else begin
               tail_q      <= bus.ram_data_out;
               tail_last_q <= push_last;
            end
         end

         if (accept) begin
            ram_address_q <= wr_idx_q;
            ram_data_in_q <= bus.in_data;
            wr_idx_q      <= wr_idx_q + 6'd1;
         end else if (issue) begin
            ram_address_q <= {rd_idx_q[2:0], rd_idx_q[5:3]};
            rd_idx_q      <= rd_idx_q + 7'd1;
         end

         case (state_q)
            FILL: begin
               if (accept && (wr_idx_q == 6'd63)) state_q <= DRAIN;
            end
            DRAIN: begin
               if (push_last) begin
                  state_q  <= FILL;
                  rd_idx_q <= '0;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign bus.in_ready    = (state_q == FILL);
   assign bus.out_valid   = (count_q != 2'd0);
   assign bus.out_data    = head_q;
   assign bus.out_last    = (count_q != 2'd0) && head_last_q;
   assign bus.ram_address = ram_address_q;
   assign bus.ram_data_in = ram_data_in_q;
   assign bus.ram_cs      = ram_cs_q;
   assign bus.ram_read    = ram_read_q;
   assign bus.ram_write   = ram_write_q;
endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Directed bench for dct_transpose_ctrl with a negedge RAM model and a
// per-cycle monitor tracking skid occupancy and RAM strobe rules.
module tb_dct_transpose_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   dct_transpose_ctrl_if #(.DATA_W(16)) bus ();

   dct_transpose_ctrl #(.DATA_W(16)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // 64x16 RAM sampling its inputs on the falling edge
   logic [15:0] mem [64] = '{default: 16'hBEEF};
   logic [15:0] rdata = 16'h0000;
   assign bus.ram_data_out = rdata;
   always @(negedge clk) begin
      if (bus.ram_cs && bus.ram_write) mem[bus.ram_address] <= bus.ram_data_in;
      if (bus.ram_cs && bus.ram_read)  rdata <= mem[bus.ram_address];
   end

   // Monitor: collect handshaken outputs, tally skid occupancy, flag rule breaks
   logic [15:0] got_data[$];
   logic        got_last[$];
   int   occ = 0, viol = 0, reads = 0, low_run = 0, last_low_run = 0;
   logic pr_rst = 1'b1, pr_read = 1'b0, pr_pop = 1'b0;

   always @(negedge clk) begin : mon
      int o;
      int bad;
      o   = pr_rst ? 0 : occ + int'(pr_read) - int'(pr_pop);
      bad = 0;
      if (bus.ram_read && bus.ram_write) bad = 1;
      if (bus.ram_cs !== (bus.ram_read | bus.ram_write)) bad = 2;
      if (o > 2 || (o + int'(bus.ram_read)) > 2) bad = 3;
      if (bus.out_valid !== (o != 0)) bad = 4;
      if (bus.out_last && !bus.out_valid) bad = 5;
      if (bad != 0) begin
         if (viol < 10) $display("FAIL invariant code=%0d t=%0t occ=%0d rd=%b wr=%b cs=%b ov=%b",
                                 bad, $time, o, bus.ram_read, bus.ram_write, bus.ram_cs, bus.out_valid);
         viol <= viol + 1;
      end
      occ     <= o;
      pr_rst  <= reset;
      pr_read <= bus.ram_read;
      pr_pop  <= bus.out_valid && bus.out_ready && !reset;
      if (bus.ram_read) reads <= reads + 1;
      if (!bus.in_ready) low_run <= low_run + 1;
      else if (low_run > 0) begin
         last_low_run <= low_run;
         low_run      <= 0;
      end
      if (!reset && bus.out_valid && bus.out_ready) begin
         got_data.push_back(bus.out_data);
         got_last.push_back(bus.out_last);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: streams nwords inputs (j<64 from base0, then base1) and waits
   // for nwords outputs. mode 0: ready high, 1: ready toggles, 2: ready low 20 cycles after last input.
   task automatic run_stream(input int nwords, input int base0, input int base1, input int mode,
                             output int first_vld, output int stall_reads, output bit done);
      int j = 0, c = 0, stall = 0, r0 = 0, acc_cyc = -1;
      int start;
      bit acc;
      start       = got_data.size();
      first_vld   = -1;
      stall_reads = -1;
      done        = 1'b0;
      while (c < 3000) begin
         if (j >= nwords && (got_data.size() - start) >= nwords) begin
            done = 1'b1;
            break;
         end
         bus.in_valid = (j < nwords);
         bus.in_data  = (j < 64) ? 16'(base0 + j) : 16'(base1 + j - 64);
         case (mode)
            1: bus.out_ready = (c % 2 == 0);
            2: begin
               if (j < nwords) bus.out_ready = 1'b1;
               else begin
                  if (stall == 0) r0 = reads;
                  if (stall == 20) stall_reads = reads - r0;
                  bus.out_ready = (stall >= 20);
                  stall++;
               end
            end
            default: bus.out_ready = 1'b1;
         endcase
         if (acc_cyc >= 0 && first_vld < 0 && bus.out_valid) first_vld = c - acc_cyc;
         acc = bus.in_valid && bus.in_ready;
         tick();
         c++;
         if (acc) begin
            j++;
            if (j == 64) acc_cyc = c;
         end
      end
      bus.in_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_last} !== 3'b100) begin
         errors++;
         $display("FAIL reset_ctrl in_ready/out_valid/out_last got=%b exp=100",
                  {bus.in_ready, bus.out_valid, bus.out_last});
      end
      checks++;
      if (bus.out_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_out_data got=%h exp=0000", bus.out_data);
      end
      checks++;
      if ({bus.ram_cs, bus.ram_read, bus.ram_write, bus.ram_address, bus.ram_data_in} !== 25'h0) begin
         errors++;
         $display("FAIL reset_ram cs=%b rd=%b wr=%b addr=%h din=%h exp all zero",
                  bus.ram_cs, bus.ram_read, bus.ram_write, bus.ram_address, bus.ram_data_in);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_frame();
      int start, fv, sr, v0;
      bit done;
      v0    = viol;
      start = got_data.size();
      run_stream(64, 0, 0, 0, fv, sr, done);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL frame_complete got=%0d words exp=64", got_data.size() - start);
      end else begin
         for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_data[start+k] !== 16'((k % 8) * 8 + k / 8) || got_last[start+k] !== (k == 63)) begin
               errors++;
               $display("FAIL frame_word k=%0d got=%0d/%b exp=%0d/%b", k, got_data[start+k],
                        got_last[start+k], (k % 8) * 8 + k / 8, k == 63);
            end
         end
      end
      checks++;
      if (fv !== 2) begin
         errors++;
         $display("FAIL frame_first_valid_latency got=%0d exp=2 cycles after last accept", fv);
      end
      checks++;
      if (last_low_run !== 65) begin
         errors++;
         $display("FAIL frame_in_ready_low got=%0d exp=65", last_low_run);
      end
      checks++;
      if (viol !== v0) begin
         errors++;
         $display("FAIL frame_invariants got=%0d violations exp=0", viol - v0);
      end
   endtask

   task automatic test_ready_toggle();
      int start, fv, sr, v0;
      bit done;
      v0    = viol;
      start = got_data.size();
      run_stream(64, 0, 0, 1, fv, sr, done);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL toggle_complete got=%0d words exp=64", got_data.size() - start);
      end else begin
         for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_data[start+k] !== 16'((k % 8) * 8 + k / 8) || got_last[start+k] !== (k == 63)) begin
               errors++;
               $display("FAIL toggle_word k=%0d got=%0d/%b exp=%0d/%b", k, got_data[start+k],
                        got_last[start+k], (k % 8) * 8 + k / 8, k == 63);
            end
         end
      end
      checks++;
      if (viol !== v0) begin
         errors++;
         $display("FAIL toggle_invariants got=%0d violations exp=0", viol - v0);
      end
   endtask

   task automatic test_stall();
      int start, fv, sr, v0;
      bit done;
      v0    = viol;
      start = got_data.size();
      run_stream(64, 0, 0, 2, fv, sr, done);
      checks++;
      if (sr !== 2) begin
         errors++;
         $display("FAIL stall_reads got=%0d exp=2", sr);
      end
      checks++;
      if (!done || got_data.size() - start !== 64) begin
         errors++;
         $display("FAIL stall_complete got=%0d words exp=64", got_data.size() - start);
      end else begin
         for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_data[start+k] !== 16'((k % 8) * 8 + k / 8)) begin
               errors++;
               $display("FAIL stall_word k=%0d got=%0d exp=%0d", k, got_data[start+k], (k % 8) * 8 + k / 8);
            end
         end
      end
      checks++;
      if (viol !== v0) begin
         errors++;
         $display("FAIL stall_invariants got=%0d violations exp=0", viol - v0);
      end
   endtask

   task automatic test_back_to_back();
      int start, fv, sr, v0, e;
      bit done;
      v0    = viol;
      start = got_data.size();
      run_stream(128, 0, 100, 0, fv, sr, done);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL b2b_complete got=%0d words exp=128", got_data.size() - start);
      end else begin
         for (int k = 0; k < 128; k++) begin
            e = ((k < 64) ? 0 : 100) + (k % 8) * 8 + (k % 64) / 8;
            checks++;
            if (got_data[start+k] !== 16'(e) || got_last[start+k] !== (k % 64 == 63)) begin
               errors++;
               $display("FAIL b2b_word k=%0d got=%0d/%b exp=%0d/%b", k, got_data[start+k],
                        got_last[start+k], e, k % 64 == 63);
            end
         end
      end
      checks++;
      if (viol !== v0) begin
         errors++;
         $display("FAIL b2b_invariants got=%0d violations exp=0", viol - v0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int start, fv, sr, v0;
      bit done;
      v0            = viol;
      bus.out_ready = 1'b1;
      for (int j = 0; j < 30; j++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'(500 + j);
         tick();
      end
      bus.in_valid = 1'b0;
      reset        = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_last, bus.out_data} !== {3'b100, 16'h0000}) begin
         errors++;
         $display("FAIL midreset_out ir=%b ov=%b ol=%b od=%h exp 1/0/0/0000",
                  bus.in_ready, bus.out_valid, bus.out_last, bus.out_data);
      end
      checks++;
      if ({bus.ram_cs, bus.ram_read, bus.ram_write, bus.ram_address, bus.ram_data_in} !== 25'h0) begin
         errors++;
         $display("FAIL midreset_ram cs=%b rd=%b wr=%b addr=%h din=%h exp all zero",
                  bus.ram_cs, bus.ram_read, bus.ram_write, bus.ram_address, bus.ram_data_in);
      end
      reset = 1'b0;
      tick();
      start = got_data.size();
      run_stream(64, 300, 0, 0, fv, sr, done);
      checks++;
      if (!done || got_data.size() - start !== 64) begin
         errors++;
         $display("FAIL midreset_complete got=%0d words exp=64", got_data.size() - start);
      end else begin
         for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_data[start+k] !== 16'(300 + (k % 8) * 8 + k / 8) || got_last[start+k] !== (k == 63)) begin
               errors++;
               $display("FAIL midreset_word k=%0d got=%0d/%b exp=%0d/%b", k, got_data[start+k],
                        got_last[start+k], 300 + (k % 8) * 8 + k / 8, k == 63);
            end
         end
      end
      checks++;
      if (viol !== v0) begin
         errors++;
         $display("FAIL midreset_invariants got=%0d violations exp=0", viol - v0);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_ready_toggle();
      test_stall();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout bench did not reach its summary");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/dct_transpose_ctrl.md
# dct_transpose_ctrl

Transpose-buffer controller for the 8-point 2D DCT. It sequences the 64x16 single-port RAM (negedge-clocked, cs/read/write) between the row-DCT and column-DCT stages. One frame of 64 row-DCT results is written in row-major order, then read back column-major into a 2-entry output skid buffer with valid/ready backpressure. FILL and DRAIN alternate; the RAM is never read and written in the same cycle.

## Interface
- DATA_W, 16, coefficient width; matches RAM word width
- clk  in  1  clock; controller logic on posedge, RAM samples its inputs on negedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  row-DCT result valid
- in_data  in  DATA_W  row-DCT result, row-major (index j = row*8+col)
- in_ready  out  1  high only in FILL
- out_valid  out  1  skid head valid
- out_data  out  DATA_W  column-major element (index k = col*8+row)
- out_last  out  1  high with element k = 63
- out_ready  in  1  column-DCT accepts
- ram_address  out  6  registered RAM address
- ram_data_in  out  DATA_W  registered RAM write data
- ram_cs, ram_read, ram_write  out  1 each  registered RAM strobes; read and write never both high
- ram_data_out  in  DATA_W  RAM read data; may be Z when not reading

## Operation
- States: FILL (reset state), DRAIN.
- FILL: in_ready=1. On in_valid&&in_ready at edge with write index j, register ram_write=1, ram_cs=1, ram_address=j, ram_data_in=in_data; j++. Otherwise ram_write=0.
- FILL->DRAIN at the edge accepting j=63; j wraps to 0; in_ready=0 from the next cycle.
- DRAIN read issue: read index k<64 and (count - pop + ram_read + 1) <= 2. count = skid occupancy (0..2), pop = out_valid&&out_ready, ram_read = current registered strobe (one read in flight).
- On issue: register ram_read=1, ram_cs=1, ram_address={k[2:0],k[5:3]}; k++. Otherwise ram_read=0.
- Capture: when ram_read is high in a cycle, ram_data_out is pushed into the skid at the end of that cycle, tagged last if it belongs to k=63.
- DRAIN->FILL at the edge capturing the k=63 data; k wraps to 0. Skid contents continue to drain during the next FILL.
- ram_cs=0 when neither strobe is asserted.
- Skid: FIFO order. out_data/out_valid/out_last always reflect the head entry. Simultaneous push and pop is legal when count=2.
- Reset: state=FILL, j=k=0, count=0.
- Reset outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, ram_cs=ram_read=ram_write=0, ram_address=0, ram_data_in=0.
- Reset mid-frame: partial frame and skid contents are discarded. RAM contents are stale and never read before being overwritten.

## Timing
- Write: accepted at edge E; RAM strobes valid in cycle E+1; RAM writes at the negedge of E+1.
- Read: issued at edge E; RAM drives data at the negedge of E+1; captured at edge E+2. out_valid is seen in cycle E+2.
- First-read latency: the last input is accepted at edge E0, first read issues at E0+1, out_valid=1 from cycle E0+3.
- Throughput: 1 word/cycle each way with out_ready held high. A frame takes 64 FILL cycles plus 65 DRAIN cycles.
- No read/write collision: the last write strobe sits in cycle E0+1; the first read strobe sits in E0+2.
- Backpressure: with out_ready=0, at most 2 entries are buffered plus 0 in flight. No data is lost or duplicated.
- in_valid is ignored in DRAIN. in_data must be held by the source until accepted.

## Test plan
- Reset then frame in_data=j (0..63), out_ready=1 -> outputs 0,8,16,...,56,1,9,...,63 in order; out_last only on 63; in_ready low for exactly 65 cycles.
- Same frame, out_ready toggling 1-0-1-0 -> identical output sequence; skid count never exceeds 2; ram_read never issued with 2 committed entries.
- out_ready=0 for 20 cycles at the start of DRAIN -> exactly 2 reads issue; after release, all 64 words arrive without gaps or duplicates.
- Two back-to-back frames (j, then 100+j) with out_ready=1 -> second frame is accepted while the skid drains; second output stream is 100,108,...,163.
- Reset asserted after 30 inputs, then a fresh frame -> all outputs are zero during reset; the fresh frame transposes correctly with no stale data.
- Every cycle: ram_read&&ram_write never true; ram_cs=ram_read|ram_write.
